// File: rtl/vlsu_pkg.sv
// Shared types for the VLSU load-meta dispatcher and shuffle unit.
// Holds descriptor/meta records, beat geometry and FSM encoding.
package vlsu_pkg;

   localparam int unsigned DefNrExits        = 4;
   localparam int unsigned DefDLEN           = 64;
   localparam int unsigned DefMaxOutstanding = 4;
   localparam int unsigned NrReqIds          = 8;
   localparam int unsigned VLBits            = 16;

   localparam int unsigned RidW      = $clog2(NrReqIds);
   localparam int unsigned BeatBytes = DefNrExits * DefDLEN / 8;
   localparam int unsigned BeatShift = $clog2(BeatBytes);
   localparam int unsigned BytesW    = VLBits + 3;
   localparam int unsigned CmtW      = BytesW - BeatShift;

   typedef logic [RidW-1:0]   rid_t;
   typedef logic [VLBits-1:0] vlen_t;
   typedef logic [CmtW-1:0]   cmt_cnt_t;

   typedef struct packed {
      rid_t       reqId;
      logic [1:0] mode;
      logic [1:0] sew;
      logic       vm;
      logic [4:0] vd;
      vlen_t      vstart;
      vlen_t      vl;
   } ld_req_t;

   typedef struct packed {
      rid_t       reqId;
      logic [1:0] mode;
      logic [1:0] sew;
      logic       vm;
      logic [4:0] vd;
      vlen_t      vstart;
      cmt_cnt_t   cmtCnt;
   } meta_glb_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DISPATCH
   } ldisp_state_e;

   typedef struct packed {
      logic [31:0] stall_full;
      logic [31:0] stall_dup;
      logic [31:0] stall_shf;
      logic [31:0] stall_seq;
   } perf_t;

endpackage

// File: rtl/vlsu_meta_fork.sv
// Two-way (N-way) stream fork: one upstream beat, independent downstream
// handshakes. Ports: valid_i/ready_o upstream, valid_o/ready_i per output.
module vlsu_meta_fork #(
   parameter int unsigned NrOut = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [NrOut-1:0] valid_o,
   input  logic [NrOut-1:0] ready_i
);

   logic [NrOut-1:0] sent_q, sent_d;

   // an output that already handshook stays quiet until the beat retires
   assign valid_o = {NrOut{valid_i}} & ~sent_q;
   assign ready_o = &(sent_q | ready_i);

   always_comb begin
      sent_d = sent_q | (valid_o & ready_i);
      if (valid_i && ready_o) sent_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sent_q <= '0;
      else         sent_q <= sent_d;
   end

endmodule

// File: rtl/vlsu_load_meta_dispatcher.sv
// Vector-load meta dispatcher: accepts load descriptors, computes commit-beat
// count, forks meta to shuffle and sequential-load units, tracks reqIds.
// Ports: req_*, shf_meta_*, seq_meta_*, vinsn_done_i, zero_done_o,
// outstanding_o, busy_o; perf_o only when VLSU_LDISP_PERF_EN is defined.
// Record widths (NrReqIds, VLBits) are fixed in vlsu_pkg.
module vlsu_load_meta_dispatcher
   import vlsu_pkg::*;
#(
   parameter int unsigned NrExits        = DefNrExits,
   parameter int unsigned DLEN           = DefDLEN,
   parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   input  ld_req_t                             req_i,
   output logic                                shf_meta_valid_o,
   input  logic                                shf_meta_ready_i,
   output meta_glb_t                           shf_meta_o,
   output logic                                seq_meta_valid_o,
   input  logic                                seq_meta_ready_i,
   output meta_glb_t                           seq_meta_o,
   input  logic [NrReqIds-1:0]                 vinsn_done_i,
   output logic [NrReqIds-1:0]                 zero_done_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
`ifdef VLSU_LDISP_PERF_EN
   output perf_t                               perf_o,
`endif
   output logic                                busy_o
);

   localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned Shift = $clog2(NrExits * DLEN / 8);

   ldisp_state_e        state_q, state_d;
   ld_req_t             req_q;
   meta_glb_t           meta_q;
   logic [NrReqIds-1:0] sb_q, sb_d, set_vec;
   logic [OutW-1:0]     out_q, out_d, done_cnt;
   logic                inc;
   vlen_t               diff;
   logic [BytesW-1:0]   bytes;
   cmt_cnt_t            cmt;
   logic                zero_len;
   logic                fork_valid, fork_ready;
   logic [1:0]          fork_vld, fork_rdy;

   assign zero_len = req_q.vl <= req_q.vstart;
   assign diff     = req_q.vl - req_q.vstart;
   assign bytes    = {3'b000, diff} << req_q.sew;
   // ceil(bytes/beat)-1 == (bytes-1)>>shift whenever bytes is non-zero
   assign cmt      = cmt_cnt_t'((bytes - BytesW'(1)) >> Shift);

   // only done bits that hit a busy reqId retire an outstanding load
   always_comb begin
      done_cnt = '0;
      for (int i = 0; i < NrReqIds; i++)
         done_cnt = done_cnt + OutW'(vinsn_done_i[i] & sb_q[i]);
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      fork_valid  = 1'b0;
      zero_done_o = '0;
      set_vec     = '0;
      inc         = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = !sb_q[req_i.reqId] &&
                          (out_q < OutW'(MaxOutstanding));
            if (req_valid_i && req_ready_o) state_d = CALC;
         end
         CALC: begin
            if (zero_len) begin
               zero_done_o[req_q.reqId] = 1'b1;
               state_d = IDLE;
            end else begin
               set_vec[req_q.reqId] = 1'b1;
               inc     = 1'b1;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            fork_valid = 1'b1;
            if (fork_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      sb_d  = (sb_q & ~vinsn_done_i) | set_vec;
      out_d = out_q + OutW'(inc) - done_cnt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sb_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         sb_q    <= sb_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q  <= '0;
         meta_q <= '0;
      end else begin
         if (state_q == IDLE && req_valid_i && req_ready_o)
            req_q <= req_i;
         if (state_q == CALC)
            meta_q <= '{reqId:  req_q.reqId,
                        mode:   req_q.mode,
                        sew:    req_q.sew,
                        vm:     req_q.vm,
                        vd:     req_q.vd,
                        vstart: req_q.vstart,
                        cmtCnt: cmt};
      end
   end

   assign fork_rdy = {seq_meta_ready_i, shf_meta_ready_i};

   vlsu_meta_fork #(
      .NrOut(2)
   ) i_fork (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .valid_i(fork_valid),
      .ready_o(fork_ready),
      .valid_o(fork_vld),
      .ready_i(fork_rdy)
   );

   assign shf_meta_valid_o = fork_vld[0];
   assign seq_meta_valid_o = fork_vld[1];
   assign shf_meta_o       = meta_q;
   assign seq_meta_o       = meta_q;
   assign outstanding_o    = out_q;
   assign busy_o           = (state_q != IDLE) || (out_q != '0);

`ifdef VLSU_LDISP_PERF_EN
   perf_t      perf_q;
   logic [3:0] stall;

   assign stall[0] = state_q == IDLE && req_valid_i &&
                     out_q == OutW'(MaxOutstanding);
   assign stall[1] = state_q == IDLE && req_valid_i && sb_q[req_i.reqId];
   assign stall[2] = shf_meta_valid_o && !shf_meta_ready_i;
   assign stall[3] = seq_meta_valid_o && !seq_meta_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else begin
         if (stall[0] && perf_q.stall_full != '1)
            perf_q.stall_full <= perf_q.stall_full + 32'd1;
         if (stall[1] && perf_q.stall_dup != '1)
            perf_q.stall_dup <= perf_q.stall_dup + 32'd1;
         if (stall[2] && perf_q.stall_shf != '1)
            perf_q.stall_shf <= perf_q.stall_shf + 32'd1;
         if (stall[3] && perf_q.stall_seq != '1)
            perf_q.stall_seq <= perf_q.stall_seq + 32'd1;
      end
   end

   assign perf_o = perf_q;
`endif

`ifndef SYNTHESIS
   a_done_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (vinsn_done_i & ~sb_q) == '0)
      else $error("vinsn_done for a reqId that is not in flight");
`endif

endmodule

// File: tb/tb_vlsu_load_meta_dispatcher.sv
// Self-checking bench for vlsu_load_meta_dispatcher.
// Reference: reqId set + in-flight count, meta from plain arithmetic.
module tb_vlsu_load_meta_dispatcher;
   import vlsu_pkg::*;

   localparam int BB = DefNrExits * DefDLEN / 8;

   logic      clk_i = 1'b0;
   logic      rst_ni = 1'b0;
   logic      req_valid_i = 1'b0;
   logic      req_ready_o;
   ld_req_t   req_i = '0;
   logic      shf_meta_valid_o;
   logic      shf_meta_ready_i = 1'b1;
   meta_glb_t shf_meta_o;
   logic      seq_meta_valid_o;
   logic      seq_meta_ready_i = 1'b1;
   meta_glb_t seq_meta_o;
   logic [7:0] vinsn_done_i = '0;
   logic [7:0] zero_done_o;
   logic [2:0] outstanding_o;
   logic      busy_o;
`ifdef VLSU_LDISP_PERF_EN
   perf_t     perf_o;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] sb_m = '0;
   int out_m = 0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   vlsu_load_meta_dispatcher dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_i           (req_i),
      .shf_meta_valid_o(shf_meta_valid_o),
      .shf_meta_ready_i(shf_meta_ready_i),
      .shf_meta_o      (shf_meta_o),
      .seq_meta_valid_o(seq_meta_valid_o),
      .seq_meta_ready_i(seq_meta_ready_i),
      .seq_meta_o      (seq_meta_o),
      .vinsn_done_i    (vinsn_done_i),
      .zero_done_o     (zero_done_o),
      .outstanding_o   (outstanding_o),
`ifdef VLSU_LDISP_PERF_EN
      .perf_o          (perf_o),
`endif
      .busy_o          (busy_o)
   );

   function automatic meta_glb_t exp_meta(input ld_req_t r);
      longint bytes;
      longint beats;
      meta_glb_t m;
      bytes = (longint'(r.vl) - longint'(r.vstart)) * (longint'(1) << r.sew);
      beats = (bytes + BB - 1) / BB;
      m.reqId = r.reqId;
      m.mode = r.mode;
      m.sew = r.sew;
      m.vm = r.vm;
      m.vd = r.vd;
      m.vstart = r.vstart;
      m.cmtCnt = cmt_cnt_t'(beats - 1);
      return m;
   endfunction

   function automatic ld_req_t mk_req(input int rid, input int vl,
                                      input int vs, input int sew);
      ld_req_t r;
      r.reqId = rid_t'(rid);
      r.mode = 2'($urandom);
      r.sew = 2'(sew);
      r.vm = 1'($urandom);
      r.vd = 5'($urandom);
      r.vstart = vlen_t'(vs);
      r.vl = vlen_t'(vl);
      return r;
   endfunction

   function automatic ld_req_t rand_req();
      ld_req_t r;
      r = mk_req($urandom_range(0, 7), 0, 0, $urandom_range(0, 3));
      case ($urandom_range(0, 3))
         0: begin
            r.vl = vlen_t'($urandom_range(0, 40));
            r.vstart = vlen_t'($urandom_range(0, 40));
         end
         1: begin
            r.vl = vlen_t'($urandom);
            r.vstart = vlen_t'($urandom);
         end
         2: begin
            r.vl = vlen_t'($urandom);
            r.vstart = '0;
         end
         default: begin
            r.vl = vlen_t'($urandom);
            r.vstart = r.vl;
         end
      endcase
      return r;
   endfunction

   // Issue one load and follow it to completion; rnd randomizes consumer ready.
   task automatic do_load(input ld_req_t r, input bit rnd);
      int n;
      bit zero, ss, sq;
      meta_glb_t em;
      logic [7:0] oh;
      zero = (r.vl <= r.vstart);
      em = exp_meta(r);
      oh = 8'h01 << r.reqId;
      req_i = r;
      req_valid_i = 1'b1;
      #1;
      n = 0;
      while (req_ready_o !== 1'b1 && n < 40) begin
         @(posedge clk_i); #1; n++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout rid=%0d got ready=%b want 1",
                  r.reqId, req_ready_o);
         req_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      #1;
      checks++;
      if (zero_done_o !== (zero ? oh : 8'h00)) begin
         errors++;
         $display("FAIL calc_zero_done got %h want %h", zero_done_o,
                  zero ? oh : 8'h00);
      end
      checks++;
      if ({shf_meta_valid_o, seq_meta_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL calc_valids got %b want 00",
                  {shf_meta_valid_o, seq_meta_valid_o});
      end
      @(posedge clk_i); #1;
      if (zero) begin
         checks++;
         if ({shf_meta_valid_o, seq_meta_valid_o, zero_done_o} !== 10'h0) begin
            errors++;
            $display("FAIL zero_after got v=%b zd=%h want 0",
                     {shf_meta_valid_o, seq_meta_valid_o}, zero_done_o);
         end
         checks++;
         if (outstanding_o !== 3'(out_m)) begin
            errors++;
            $display("FAIL zero_outstanding got %0d want %0d",
                     outstanding_o, out_m);
         end
         return;
      end
      sb_m[r.reqId] = 1'b1;
      out_m++;
      checks++;
      if (outstanding_o !== 3'(out_m)) begin
         errors++;
         $display("FAIL outstanding_inc got %0d want %0d", outstanding_o, out_m);
      end
      ss = 0;
      sq = 0;
      n = 0;
      while (!(ss && sq) && n < 40) begin
         shf_meta_ready_i = rnd ? 1'($urandom) : 1'b1;
         seq_meta_ready_i = rnd ? 1'($urandom) : 1'b1;
         #1;
         checks++;
         if (shf_meta_valid_o !== !ss || seq_meta_valid_o !== !sq) begin
            errors++;
            $display("FAIL dispatch_valids got %b%b want %b%b",
                     shf_meta_valid_o, seq_meta_valid_o, !ss, !sq);
         end
         checks++;
         if ((!ss && shf_meta_o !== em) || (!sq && seq_meta_o !== em)) begin
            errors++;
            $display("FAIL meta_payload got shf=%h seq=%h want %h",
                     shf_meta_o, seq_meta_o, em);
         end
         if (shf_meta_ready_i) ss = 1;
         if (seq_meta_ready_i) sq = 1;
         @(posedge clk_i); #1;
         n++;
      end
      shf_meta_ready_i = 1'b1;
      seq_meta_ready_i = 1'b1;
      checks++;
      if (n >= 40 || {shf_meta_valid_o, seq_meta_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL dispatch_end got v=%b%b n=%0d want 00",
                  shf_meta_valid_o, seq_meta_valid_o, n);
      end
   endtask

   task automatic pulse_done(input logic [7:0] m);
      vinsn_done_i = m;
      @(posedge clk_i); #1;
      vinsn_done_i = '0;
      for (int i = 0; i < 8; i++)
         if (m[i] && sb_m[i]) begin
            sb_m[i] = 1'b0;
            out_m--;
         end
      #1;
      checks++;
      if (outstanding_o !== 3'(out_m)) begin
         errors++;
         $display("FAIL done_outstanding got %0d want %0d", outstanding_o, out_m);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #12;
      checks++;
      if ({shf_meta_valid_o, seq_meta_valid_o, zero_done_o, outstanding_o,
           busy_o} !== 14'h0) begin
         errors++;
         $display("FAIL reset_state got v=%b%b zd=%h out=%0d busy=%b want 0",
                  shf_meta_valid_o, seq_meta_valid_o, zero_done_o,
                  outstanding_o, busy_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_single();
      do_load(mk_req(0, 16, 0, 2), 0);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL single_busy got %b want 1", busy_o);
      end
      pulse_done(8'h01);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got %b want 0", busy_o);
      end
   endtask

   task automatic test_zero();
      do_load(mk_req(6, 5, 5, 1), 0);
      do_load(mk_req(2, 3, 9, 0), 0);
   endtask

   task automatic test_cmt_boundary();
      do_load(mk_req(1, 8, 0, 2), 0);
      do_load(mk_req(2, 33, 0, 0), 0);
      do_load(mk_req(3, 1, 0, 0), 0);
      do_load(mk_req(4, 65535, 0, 3), 0);
      pulse_done(8'h1e);
   endtask

   task automatic test_backpressure();
      ld_req_t r;
      meta_glb_t em;
      r = mk_req(5, 20, 3, 1);
      em = exp_meta(r);
      shf_meta_ready_i = 1'b0;
      seq_meta_ready_i = 1'b1;
      req_i = r;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      req_i.reqId = 3'd7;
      @(posedge clk_i); #1;
      checks++;
      if ({shf_meta_valid_o, seq_meta_valid_o} !== 2'b11) begin
         errors++;
         $display("FAIL bp_start got %b%b want 11",
                  shf_meta_valid_o, seq_meta_valid_o);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (shf_meta_valid_o !== 1'b1 || seq_meta_valid_o !== 1'b0 ||
             shf_meta_o !== em || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold k=%0d got v=%b%b rdy=%b meta=%h want 10 0 %h",
                     k, shf_meta_valid_o, seq_meta_valid_o, req_ready_o,
                     shf_meta_o, em);
         end
      end
      shf_meta_ready_i = 1'b1;
      @(posedge clk_i); #1;
      sb_m[5] = 1'b1;
      out_m++;
      checks++;
      if (shf_meta_valid_o !== 1'b0 || req_ready_o !== 1'b1 ||
          outstanding_o !== 3'(out_m)) begin
         errors++;
         $display("FAIL bp_release got v=%b rdy=%b out=%0d want 0 1 %0d",
                  shf_meta_valid_o, req_ready_o, outstanding_o, out_m);
      end
      pulse_done(8'h20);
   endtask

   task automatic test_back_to_back();
      int t_acc[3];
      int n;
      req_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_i = mk_req(k, 40, 0, 3);
         #1;
         n = 0;
         while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1; n++;
         end
         t_acc[k] = cyc;
         @(posedge clk_i); #1;
         sb_m[k] = 1'b1;
         out_m++;
      end
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      checks++;
      if (t_acc[1] - t_acc[0] !== 3 || t_acc[2] - t_acc[1] !== 3) begin
         errors++;
         $display("FAIL b2b_spacing got %0d,%0d want 3,3",
                  t_acc[1] - t_acc[0], t_acc[2] - t_acc[1]);
      end
      checks++;
      if (outstanding_o !== 3'(out_m)) begin
         errors++;
         $display("FAIL b2b_outstanding got %0d want %0d", outstanding_o, out_m);
      end
      pulse_done(8'h07);
   endtask

   task automatic test_full_and_dup();
      ld_req_t r4, r3;
      for (int k = 0; k < 4; k++) do_load(mk_req(k, 64, 0, 2), 0);
      r4 = mk_req(4, 100, 1, 1);
      req_i = r4;
      req_valid_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin
         errors++;
         $display("FAIL full_stall got rdy=%b out=%0d want 0 4",
                  req_ready_o, outstanding_o);
      end
      @(posedge clk_i); #1;
      vinsn_done_i = 8'h04;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full_done_same_cycle got %b want 0", req_ready_o);
      end
      @(posedge clk_i); #1;
      vinsn_done_i = '0;
      sb_m[2] = 1'b0;
      out_m--;
      #1;
      checks++;
      if (req_ready_o !== 1'b1 || outstanding_o !== 3'd3) begin
         errors++;
         $display("FAIL full_release got rdy=%b out=%0d want 1 3",
                  req_ready_o, outstanding_o);
      end
      do_load(r4, 0);
      pulse_done(8'h03);
      r3 = mk_req(3, 7, 2, 0);
      req_i = r3;
      req_valid_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL dup_stall k=%0d got %b want 0", k, req_ready_o);
         end
         @(posedge clk_i); #1;
      end
      vinsn_done_i = 8'h08;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL dup_done_same_cycle got %b want 0", req_ready_o);
      end
      @(posedge clk_i); #1;
      vinsn_done_i = '0;
      sb_m[3] = 1'b0;
      out_m--;
      do_load(r3, 0);
      pulse_done(sb_m);
   endtask

   task automatic test_random();
      ld_req_t r;
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 9) < 3 && sb_m != '0) begin
            pulse_done(sb_m & 8'($urandom));
         end else begin
            r = rand_req();
            if (sb_m[r.reqId] || out_m >= DefMaxOutstanding) begin
               req_i = r;
               req_valid_i = 1'b1;
               #1;
               checks++;
               if (req_ready_o !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_stall rid=%0d got %b want 0",
                           r.reqId, req_ready_o);
               end
               @(posedge clk_i); #1;
               req_valid_i = 1'b0;
            end else begin
               do_load(r, 1);
            end
         end
      end
      pulse_done(sb_m);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      shf_meta_ready_i = 1'b0;
      seq_meta_ready_i = 1'b0;
      req_i = mk_req(2, 30, 0, 2);
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      checks++;
      if ({shf_meta_valid_o, seq_meta_valid_o} !== 2'b11 ||
          outstanding_o !== 3'd1) begin
         errors++;
         $display("FAIL rstmid_pre got v=%b%b out=%0d want 11 1",
                  shf_meta_valid_o, seq_meta_valid_o, outstanding_o);
      end
      #1;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({shf_meta_valid_o, seq_meta_valid_o} !== 2'b00 ||
          outstanding_o !== 3'd0 || busy_o !== 1'b0 ||
          req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_clear got v=%b%b out=%0d busy=%b rdy=%b want 00 0 0 1",
                  shf_meta_valid_o, seq_meta_valid_o, outstanding_o,
                  busy_o, req_ready_o);
      end
`ifdef VLSU_LDISP_PERF_EN
      checks++;
      if (perf_o !== '0) begin
         errors++;
         $display("FAIL rstmid_perf got %h want 0", perf_o);
      end
`endif
      sb_m = '0;
      out_m = 0;
      shf_meta_ready_i = 1'b1;
      seq_meta_ready_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      do_load(mk_req(2, 9, 1, 1), 0);
      pulse_done(8'h04);
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_cmt_boundary();
      test_backpressure();
      test_back_to_back();
      test_full_and_dup();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

endmodule
